// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between N byte-stream requesters, the shared UART
// transmit path and the arbiter that sits between them.
//
// Handshake rule for both the req_* and tx_* pairs: a byte moves on a rising
// clock edge where valid and ready are both 1. A requester may withdraw
// valid, which simply stalls its packet. While the arbiter presents a header
// byte, it holds tx_valid and tx_data until tx_ready is seen.
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic [1:0]     state_dbg;

    // Requesters plus transmitter side (environment).
    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data, grant, busy, state_dbg
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data, grant, busy, state_dbg
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmit byte path between N
// packet requesters. The grant is held for a whole packet, or for at most
// MAX_PKT bytes. An optional header byte (HDR_BASE | id) is sent whenever the
// serviced channel differs from the last one serviced.
module uart_tx_arbiter #(
    parameter int         N        = 4,
    parameter bit         HDR_EN   = 1'b1,
    parameter logic [7:0] HDR_BASE = 8'hF0,
    parameter int         MAX_PKT  = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (MAX_PKT >= 1) ? $clog2(MAX_PKT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PKT - 1);

    if (N < 2 || N > 16) begin : g_bad_n
        $fatal(1, "uart_tx_arbiter: N must be in 2..16");
    end
    if ((int'(HDR_BASE) % (1 << IW)) != 0) begin : g_bad_base
        $fatal(1, "uart_tx_arbiter: low id bits of HDR_BASE must be zero");
    end
    if (MAX_PKT < 1) begin : g_bad_max
        $fatal(1, "uart_tx_arbiter: MAX_PKT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] gid_q;
    logic [IW-1:0] last_id_q;
    logic          last_vld_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    hdr_q;

    logic [IW-1:0] pick;
    logic          any_req;
    logic          xfer;
    logic          release_pkt;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  grant;
    logic [N-1:0]  gid_onehot;

    assign gid_onehot = {{(N-1){1'b0}}, 1'b1} << gid_q;

    // Round-robin scan: first requester with valid, starting at ptr and wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        pick    = '0;
        any_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!any_req && bus.req_valid[idx]) begin
                any_req = 1'b1;
                pick    = IW'(idx);
            end
        end
    end

    // Next-state and output decode; DATA passes the granted requester straight through.
    always_comb begin
        state_d     = state_q;
        xfer        = 1'b0;
        release_pkt = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = hdr_q;
        req_ready   = '0;
        grant       = '0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    if (HDR_EN && (!last_vld_q || pick != last_id_q)) state_d = S_HDR;
                    else                                               state_d = S_DATA;
                end
            end
            S_HDR: begin
                tx_valid = 1'b1;
                grant    = gid_onehot;
                if (bus.tx_ready) begin
                    xfer    = 1'b1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_valid         = bus.req_valid[gid_q];
                tx_data          = bus.req_data[8*gid_q +: 8];
                req_ready[gid_q] = bus.tx_ready;
                grant            = gid_onehot;
                if (tx_valid && bus.tx_ready) begin
                    xfer = 1'b1;
                    if (bus.req_last[gid_q] || cnt_q == CNT_LAST) begin
                        release_pkt = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Grant bookkeeping: owner, header byte, last serviced id, byte count, rotation pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q      <= '0;
            gid_q      <= '0;
            last_id_q  <= '0;
            last_vld_q <= 1'b0;
            cnt_q      <= '0;
            hdr_q      <= 8'h00;
        end else begin
            if (state_q == S_IDLE && any_req) begin
                gid_q <= pick;
                cnt_q <= '0;
                hdr_q <= HDR_BASE | 8'(pick);
            end
            if (xfer) begin
                last_id_q  <= gid_q;
                last_vld_q <= 1'b1;
            end
            // The count restarts at release, so it never rests at MAX_PKT.
            if (xfer && state_q == S_DATA) begin
                cnt_q <= release_pkt ? '0 : cnt_q + 1'b1;
            end
            if (release_pkt) begin
                ptr_q <= (gid_q == IW'(N - 1)) ? '0 : gid_q + 1'b1;
            end
        end
    end

    // The byte counter must stay below the per-grant limit.
    always @(posedge clk) begin
        if (reset_n) begin
            assert (int'(cnt_q) < MAX_PKT)
                else $fatal(1, "uart_tx_arbiter: byte count reached MAX_PKT");
        end
    end

    assign bus.tx_valid  = tx_valid;
    assign bus.tx_data   = tx_data;
    assign bus.req_ready = req_ready;
    assign bus.grant     = grant;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: N=4, headers on, HDR_BASE=F0, MAX_PKT=4.
module tb_uart_tx_arbiter;
    localparam int         N    = 4;
    localparam logic [7:0] HB   = 8'hF0;
    localparam int         MAXP = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    uart_tx_arbiter_if #(.N(N)) bus ();

    uart_tx_arbiter #(
        .N(N), .HDR_EN(1'b1), .HDR_BASE(HB), .MAX_PKT(MAXP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Requester packet queues: {last, byte}.
    logic [8:0] src_q[N][$];
    // Expected tx bytes for the current grant: {is_header, byte}.
    logic [8:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] want_q[$];

    // Reference model of the arbitration rules.
    bit m_idle = 1'b1;
    int m_gid = 0;
    int m_ptr = 0;
    int m_last_id = 0;
    bit m_last_vld = 1'b0;
    bit gap_en = 1'b0;
    logic [N-1:0] drv_v;

    typedef struct {
        logic [N-1:0] v;
        logic [7:0]   d;
        logic         l;
        logic         tr;
        logic         busy;
        logic [N-1:0] grant;
        logic         txv;
        logic [7:0]   txd;
        logic [N-1:0] rdy;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_idle = 1'b1; m_gid = 0; m_ptr = 0; m_last_id = 0; m_last_vld = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_ready = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic add_packet(input int ch, input int len);
        logic [7:0] b;
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom_range(0, 255));
            src_q[ch].push_back({(k == len - 1), b});
        end
    endtask

    // Expected bytes of a new grant: header if the channel changed, then up to MAXP bytes or the end of the packet.
    task automatic plan_grant(input int w);
        logic [8:0] e;
        if (!m_last_vld || w != m_last_id) exp_q.push_back({1'b1, HB | 8'(w)});
        for (int k = 0; k < src_q[w].size() && k < MAXP; k++) begin
            e = src_q[w][k];
            exp_q.push_back({1'b0, e[7:0]});
            if (e[8]) break;
        end
    endtask

    task automatic drive_inputs(input logic tr);
        logic [8*N-1:0] d;
        logic [N-1:0] l;
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            drv_v[i] = (src_q[i].size() > 0) && !(gap_en && $urandom_range(0, 7) == 0);
            if (src_q[i].size() > 0) begin
                h = src_q[i][0];
                d[8*i +: 8] = h[7:0];
                l[i] = h[8];
            end else begin
                d[8*i +: 8] = 8'($urandom_range(0, 255));
                l[i] = 1'($urandom_range(0, 1));
            end
        end
        bus.req_valid = drv_v;
        bus.req_data  = d;
        bus.req_last  = l;
        bus.tx_ready  = tr;
    endtask

    // One clock of queue-driven stimulus, checked against the model at the falling edge.
    task automatic run_cycle(input logic tr);
        logic [N-1:0] rdy_seen;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_grant;
        logic [8:0]   front;
        logic         exp_txv;
        bit           found;
        drive_inputs(tr);
        @(negedge clk);
        exp_grant = m_idle ? '0 : onehot(m_gid);
        front = (exp_q.size() > 0) ? exp_q[0] : 9'h0;
        if (m_idle) begin
            exp_txv = 1'b0; exp_rdy = '0;
        end else if (front[8]) begin
            exp_txv = 1'b1; exp_rdy = '0;
        end else begin
            exp_txv = drv_v[m_gid];
            exp_rdy = tr ? onehot(m_gid) : '0;
        end
        check("busy", 32'(bus.busy), 32'(!m_idle));
        check("grant", 32'(bus.grant), 32'(exp_grant));
        check("tx_valid", 32'(bus.tx_valid), 32'(exp_txv));
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (exp_txv) check("tx_data", 32'(bus.tx_data), 32'(front[7:0]));
        if (bus.tx_valid && tr) got_q.push_back(bus.tx_data);
        rdy_seen = bus.req_ready;
        if (m_idle) begin
            if (drv_v != '0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && drv_v[(m_ptr + k) % N]) begin
                        found = 1'b1;
                        m_gid = (m_ptr + k) % N;
                    end
                end
                plan_grant(m_gid);
                m_idle = 1'b0;
            end
        end else if (exp_txv && tr) begin
            void'(exp_q.pop_front());
            m_last_id = m_gid;
            m_last_vld = 1'b1;
            if (exp_q.size() == 0) begin
                m_idle = 1'b1;
                m_ptr = (m_gid + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (drv_v[i] && rdy_seen[i]) void'(src_q[i].pop_front());
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((pending() || !m_idle) && n < 400) begin
            run_cycle(1'b1);
            n++;
        end
        check({name, "_drain_in_time"}, 32'(n < 400), 32'd1);
        run_cycle(1'b1);
    endtask

    task automatic check_stream(input string name);
        check({name, "_len"}, 32'(got_q.size()), 32'(want_q.size()));
        for (int k = 0; k < want_q.size() && k < got_q.size(); k++)
            check($sformatf("%s_byte%0d", name, k), 32'(got_q[k]), 32'(want_q[k]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while reset is held.
        bus.req_valid = 4'b1111; bus.req_data = '1; bus.req_last = '0; bus.tx_ready = 1'b1;
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h00);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);

        // Table: ch2 packet {11,22} then a back-to-back packet {33,44}.
        vecs[0] = '{4'b0100, 8'h11, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000};
        vecs[1] = '{4'b0100, 8'h11, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 8'hF2, 4'b0000};
        vecs[2] = '{4'b0100, 8'h11, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 8'h11, 4'b0100};
        vecs[3] = '{4'b0100, 8'h22, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 8'h22, 4'b0100};
        vecs[4] = '{4'b0100, 8'h33, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000};
        vecs[5] = '{4'b0100, 8'h33, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 8'h33, 4'b0100};
        vecs[6] = '{4'b0100, 8'h44, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 8'h44, 4'b0100};
        vecs[7] = '{4'b0000, 8'h00, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000};
        do_reset();
        for (int r = 0; r < 8; r++) begin
            bus.req_valid = vecs[r].v;
            bus.req_data  = {8'h5A, vecs[r].d, 8'hA5, 8'h3C};
            bus.req_last  = {1'b1, vecs[r].l, 2'b11};
            bus.tx_ready  = vecs[r].tr;
            @(negedge clk);
            check($sformatf("vec%0d_busy", r), 32'(bus.busy), 32'(vecs[r].busy));
            check($sformatf("vec%0d_grant", r), 32'(bus.grant), 32'(vecs[r].grant));
            check($sformatf("vec%0d_tx_valid", r), 32'(bus.tx_valid), 32'(vecs[r].txv));
            check($sformatf("vec%0d_req_ready", r), 32'(bus.req_ready), 32'(vecs[r].rdy));
            if (vecs[r].txv) check($sformatf("vec%0d_tx_data", r), 32'(bus.tx_data), 32'(vecs[r].txd));
            @(posedge clk);
            #1;
        end

        // Round-robin: every channel has two 1-byte packets pending.
        do_reset();
        for (int i = 0; i < N; i++) begin
            src_q[i].push_back({1'b1, 8'hA0 + 8'(i)});
            src_q[i].push_back({1'b1, 8'hB0 + 8'(i)});
        end
        drain("rr");
        want_q = '{8'hF0, 8'hA0, 8'hF1, 8'hA1, 8'hF2, 8'hA2, 8'hF3, 8'hA3,
                   8'hF0, 8'hB0, 8'hF1, 8'hB1, 8'hF2, 8'hB2, 8'hF3, 8'hB3};
        check_stream("rr");

        // Forced release at MAXP=4 with ch3 waiting.
        do_reset();
        for (int k = 0; k < 6; k++) src_q[1].push_back({(k == 5), 8'h51 + 8'(k)});
        src_q[3].push_back({1'b1, 8'h71});
        drain("force");
        want_q = '{8'hF1, 8'h51, 8'h52, 8'h53, 8'h54, 8'hF3, 8'h71, 8'hF1, 8'h55, 8'h56};
        check_stream("force");

        // Backpressure: tx_ready low 5 cycles in HDR and 5 cycles in DATA.
        do_reset();
        src_q[0].push_back({1'b0, 8'hA1});
        src_q[0].push_back({1'b1, 8'hA2});
        run_cycle(1'b1);
        repeat (5) run_cycle(1'b0);
        run_cycle(1'b1);
        repeat (5) run_cycle(1'b0);
        drain("bp");
        want_q = '{8'hF0, 8'hA1, 8'hA2};
        check_stream("bp");

        // Reset mid-packet: outputs clear asynchronously; the resumed packet gets a header.
        do_reset();
        src_q[2].push_back({1'b0, 8'h31});
        src_q[2].push_back({1'b0, 8'h32});
        src_q[2].push_back({1'b1, 8'h33});
        repeat (3) run_cycle(1'b1);
        check("mid_busy_before", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_grant", 32'(bus.grant), 32'd0);
        check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("mid_rst_tx_data", 32'(bus.tx_data), 32'h00);
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        drain("midrst");
        want_q = '{8'hF2, 8'h32, 8'h33};
        check_stream("midrst");

        // Randomized traffic, valid gaps and tx backpressure against the model.
        do_reset();
        gap_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            int ch;
            ch = $urandom_range(0, N - 1);
            if ($urandom_range(0, 3) == 0 && src_q[ch].size() < 12)
                add_packet(ch, $urandom_range(1, 7));
            run_cycle($urandom_range(0, 3) != 0);
        end
        gap_en = 1'b0;
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
